traffic_phase_controller: RTL
=============================

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the phase timer.
REQ-002 SHALL have parameter GREEN_TICKS, default 20: main green duration in ticks.
REQ-003 SHALL have parameter AMBER_TICKS, default 4: amber duration and left-arrow clearance duration.
REQ-004 SHALL have parameter ALLRED_TICKS, default 2: all-red clearance duration.
REQ-005 SHALL have parameter LEFT_TICKS, default 8: southbound protected-left duration.
REQ-006 SHALL have parameter WALK_TICKS, default 8: walk duration.
REQ-007 SHALL have parameter FDW_TICKS, default 6: flashing-don't-walk duration.
REQ-008 SHALL have these ports:
- clk  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle timebase enable.
- flash_mode  in  1  night/fault flash request, level-sensitive.
- sb_left_req  in  1  southbound left-turn request.
- ns_walk_req  in  1  NS pedestrian request.
- ew_walk_req  in  1  EW pedestrian request.
- ns_light  out  2  NS vehicle light: 0 red, 1 amber, 2 green, 3 dark.
- ew_light  out  2  EW vehicle light, same encoding as ns_light.
- sb_left  out  1  southbound left arrow.
- ns_ped  out  2  NS pedestrian signal: 0 don't walk, 1 flashing don't walk, 2 walk, 3 dark.
- ew_ped  out  2  EW pedestrian signal, same encoding as ns_ped.
- state  out  4  current FSM state, for debug.
- timer  out  CNT_W  remaining ticks in the current phase, for debug.
- pending  out  3  latched requests {sb_left, ns_walk, ew_walk}.

Function
REQ-009 SHALL implement these states: NS_GREEN, NS_AMBER, ALLRED_NS, EW_GREEN, EW_AMBER, ALLRED_EW, SB_LEFT, SB_LEFT_CLR, FLASH.
REQ-010 SHALL load timer with duration-1 on entering a timed state; SHALL decrement timer only when tick=1; SHALL leave the state on a cycle where tick=1 and timer=0.
REQ-011 SHALL follow this sequence: NS_GREEN -> NS_AMBER -> ALLRED_NS -> EW_GREEN -> EW_AMBER -> ALLRED_EW -> (SB_LEFT -> SB_LEFT_CLR if the left request is pending) -> NS_GREEN.
REQ-012 SHALL set a pending bit whenever its request input is 1 on any cycle.
REQ-013 SHALL clear a pending bit on the cycle its phase is entered: NS_GREEN clears ns_walk, EW_GREEN clears ew_walk, SB_LEFT clears sb_left.
REQ-014 SHALL let set win when a request is asserted in the same cycle as its clear, leaving the bit pending for the next round.
REQ-015 SHALL capture, at green entry, whether the walk for that street is served; if served, ped SHALL be walk for WALK_TICKS, then flashing for FDW_TICKS, then don't walk for the rest of the green; otherwise ped SHALL stay don't walk.
REQ-016 SHALL drive: green street = 2, amber street = 1, all other vehicle lights = 0.
REQ-017 SHALL assert sb_left=1 only in SB_LEFT, with ns_light and ew_light = 0 during SB_LEFT and SB_LEFT_CLR.
REQ-018 SHALL drive ped=0 outside a served green.
REQ-019 SHALL, when flash_mode=1, enter FLASH only at the expiry of ALLRED_NS or ALLRED_EW, never mid-green.
REQ-020 SHALL, in FLASH, toggle a phase bit on each tick: ns_light alternates amber/dark, ew_light alternates red/dark, sb_left=0, peds=3.
REQ-021 SHALL keep latching requests in FLASH without serving them.
REQ-022 SHALL, when flash_mode=0 in FLASH, go to ALLRED_EW on the next tick.
REQ-023 SHALL require every *_TICKS >= 1, every *_TICKS < 2^CNT_W, and WALK_TICKS+FDW_TICKS <= GREEN_TICKS; an elaboration-time check SHALL fail otherwise.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set state=ALLRED_EW, timer=ALLRED_TICKS-1, pending=0, flash phase=0, ns_light=0, ew_light=0, sb_left=0, ns_ped=0, ew_ped=0.
REQ-025 SHALL make reset dominant over tick and requests, and a mid-phase reset SHALL abandon the phase immediately.

Structure
REQ-026 SHALL place the state enum, the light and ped encodings and the state width in package traffic_pkg.
REQ-027 SHALL use one sub-module, phase_timer: loadable down-counter with tick enable and an expiry flag.

Verification
REQ-028 Bench SHALL use GREEN=6, AMBER=2, ALLRED=1, LEFT=3, WALK=2, FDW=2, tick=1 every cycle.
REQ-029 Scenario: reset, no requests -> sequence ALLRED_EW(1), NS_GREEN(6), NS_AMBER(2), ALLRED_NS(1), EW_GREEN(6); all peds 0.
REQ-030 Scenario: ns_walk_req pulse during EW_GREEN -> next NS_GREEN shows ns_ped 2,2,1,1,0,0 and pending[1] clears at entry.
REQ-031 Scenario: sb_left_req during NS_GREEN -> after ALLRED_EW, SB_LEFT for 3 cycles with sb_left=1, then SB_LEFT_CLR for 2 cycles, then NS_GREEN.
REQ-032 Scenario: ns_walk_req on the NS_GREEN entry cycle -> pending[1] stays 1 and the walk is served on the following NS_GREEN.
REQ-033 Scenario: flash_mode=1 mid NS_GREEN -> green completes, FLASH entered after ALLRED_NS, ns_light toggles 1/3; flash_mode=0 -> ALLRED_EW next tick.
REQ-034 Scenario: reset asserted in cycle 3 of EW_GREEN -> next cycle state=ALLRED_EW, all outputs at reset values.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase controller: FSM states, vehicle
// light codes and pedestrian signal codes.
package traffic_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        NS_GREEN    = 4'd0,
        NS_AMBER    = 4'd1,
        ALLRED_NS   = 4'd2,
        EW_GREEN    = 4'd3,
        EW_AMBER    = 4'd4,
        ALLRED_EW   = 4'd5,
        SB_LEFT     = 4'd6,
        SB_LEFT_CLR = 4'd7,
        FLASH       = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        LIGHT_RED   = 2'd0,
        LIGHT_AMBER = 2'd1,
        LIGHT_GREEN = 2'd2,
        LIGHT_DARK  = 2'd3
    } light_t;

    typedef enum logic [1:0] {
        PED_DONT_WALK = 2'd0,
        PED_FLASH_DW  = 2'd1,
        PED_WALK      = 2'd2,
        PED_DARK      = 2'd3
    } ped_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations. Counts only on tick, holds at
// zero, and flags expiry while the count is zero.
module phase_timer #(
    parameter int          CNT_W     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CNT_W'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-street intersection controller with southbound protected left,
// latched pedestrian requests and a flashing night/fault mode.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int AMBER_TICKS  = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int LEFT_TICKS   = 8,
    parameter int WALK_TICKS   = 8,
    parameter int FDW_TICKS    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             flash_mode,
    input  logic             sb_left_req,
    input  logic             ns_walk_req,
    input  logic             ew_walk_req,
    output logic [1:0]       ns_light,
    output logic [1:0]       ew_light,
    output logic             sb_left,
    output logic [1:0]       ns_ped,
    output logic [1:0]       ew_ped,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] timer,
    output logic [2:0]       pending
);

    localparam int LIMIT = 1 << CNT_W;

    if (GREEN_TICKS < 1 || AMBER_TICKS < 1 || ALLRED_TICKS < 1 || LEFT_TICKS < 1 ||
        WALK_TICKS < 1 || FDW_TICKS < 1 ||
        GREEN_TICKS >= LIMIT || AMBER_TICKS >= LIMIT || ALLRED_TICKS >= LIMIT ||
        LEFT_TICKS >= LIMIT || WALK_TICKS >= LIMIT || FDW_TICKS >= LIMIT ||
        (WALK_TICKS + FDW_TICKS) > GREEN_TICKS) begin : g_bad_params
        $error("traffic_phase_controller: illegal tick parameters");
    end

    // Timer thresholds: green counts down from GREEN_TICKS-1, so walk holds
    // while timer >= WALK_EDGE and flashing holds while timer >= FDW_EDGE.
    localparam logic [CNT_W-1:0] WALK_EDGE = CNT_W'(GREEN_TICKS - WALK_TICKS);
    localparam logic [CNT_W-1:0] FDW_EDGE  = CNT_W'(GREEN_TICKS - WALK_TICKS - FDW_TICKS);

    state_t           state_q, state_d;
    logic [2:0]       pending_q;
    logic             ns_served_q, ew_served_q, flash_phase_q;
    logic             load, expired, advance;
    logic [CNT_W-1:0] load_val, count;
    logic             enter_ns, enter_ew, enter_sb;

    phase_timer #(.CNT_W(CNT_W), .RESET_VAL(ALLRED_TICKS - 1)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .expired  (expired)
    );

    assign advance = tick && expired;

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:    if (advance) state_d = NS_AMBER;
            NS_AMBER:    if (advance) state_d = ALLRED_NS;
            ALLRED_NS:   if (advance) state_d = flash_mode ? FLASH : EW_GREEN;
            EW_GREEN:    if (advance) state_d = EW_AMBER;
            EW_AMBER:    if (advance) state_d = ALLRED_EW;
            ALLRED_EW:   if (advance) state_d = flash_mode ? FLASH
                                              : (pending_q[2] ? SB_LEFT : NS_GREEN);
            SB_LEFT:     if (advance) state_d = SB_LEFT_CLR;
            SB_LEFT_CLR: if (advance) state_d = NS_GREEN;
            FLASH:       if (tick && !flash_mode) state_d = ALLRED_EW;
            default:     state_d = ALLRED_EW;
        endcase
    end

    assign load = (state_d != state_q);

    always_comb begin
        load_val = '0;
        case (state_d)
            NS_GREEN, EW_GREEN:              load_val = CNT_W'(GREEN_TICKS - 1);
            NS_AMBER, EW_AMBER, SB_LEFT_CLR: load_val = CNT_W'(AMBER_TICKS - 1);
            ALLRED_NS, ALLRED_EW:            load_val = CNT_W'(ALLRED_TICKS - 1);
            SB_LEFT:                         load_val = CNT_W'(LEFT_TICKS - 1);
            default:                         load_val = '0;
        endcase
    end

    assign enter_ns = load && (state_d == NS_GREEN);
    assign enter_ew = load && (state_d == EW_GREEN);
    assign enter_sb = load && (state_d == SB_LEFT);

    // A request arriving on the clearing edge survives into the next round.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ALLRED_EW;
            pending_q     <= '0;
            ns_served_q   <= 1'b0;
            ew_served_q   <= 1'b0;
            flash_phase_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= (pending_q & ~{enter_sb, enter_ns, enter_ew})
                       | {sb_left_req, ns_walk_req, ew_walk_req};
            if (enter_ns) ns_served_q <= pending_q[1];
            if (enter_ew) ew_served_q <= pending_q[0];
            if (state_q != FLASH) flash_phase_q <= 1'b0;
            else if (tick)        flash_phase_q <= ~flash_phase_q;
        end
    end

    function automatic ped_t green_ped(input logic served, input logic [CNT_W-1:0] t);
        if (!served)            return PED_DONT_WALK;
        else if (t >= WALK_EDGE) return PED_WALK;
        else if (t >= FDW_EDGE)  return PED_FLASH_DW;
        else                    return PED_DONT_WALK;
    endfunction

    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        sb_left  = 1'b0;
        ns_ped   = PED_DONT_WALK;
        ew_ped   = PED_DONT_WALK;
        case (state_q)
            NS_GREEN: begin
                ns_light = LIGHT_GREEN;
                ns_ped   = green_ped(ns_served_q, count);
            end
            NS_AMBER: ns_light = LIGHT_AMBER;
            EW_GREEN: begin
                ew_light = LIGHT_GREEN;
                ew_ped   = green_ped(ew_served_q, count);
            end
            EW_AMBER: ew_light = LIGHT_AMBER;
            SB_LEFT:  sb_left  = 1'b1;
            FLASH: begin
                ns_light = flash_phase_q ? LIGHT_DARK : LIGHT_AMBER;
                ew_light = flash_phase_q ? LIGHT_DARK : LIGHT_RED;
                ns_ped   = PED_DARK;
                ew_ped   = PED_DARK;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign timer   = count;
    assign pending = pending_q;

endmodule
